// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared types and constants for the flappy bird datapath
//
// Used by pipe_scroller, the collision detector and the renderer.
//   SCREEN_WIDTH    visible width in pixels
//   X_W / Y_W       output coordinate widths
//   PX_W            internal signed pipe left-edge width
//   pipe_t          one pipe: left edge, gap bottom (y0), gap top (y1)
//   scroll_state_t  scroller play state
//   sat_x           clamp a signed x value into the 0..1023 output range
package flappy_pkg;

  localparam int SCREEN_WIDTH = 640;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int PX_W         = 12;

  typedef struct packed {
    logic signed [PX_W-1:0] px;
    logic [Y_W-1:0]         y0;
    logic [Y_W-1:0]         y1;
  } pipe_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } scroll_state_t;

  function automatic logic [X_W-1:0] sat_x(input logic signed [PX_W:0] v);
    if (v < 0)
      return '0;
    else if (v > 13'sd1023)
      return '1;
    else
      return v[X_W-1:0];
  endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-low reset, loads the seed
//   en     in   advance one step this cycle
//   q      out  current register value
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  logic feedback;
  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (!reset)
      q <= 8'hA5;
    else if (en)
      q <= {q[6:0], feedback};
  end

endmodule

// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - scrolls and respawns the three pipe obstacles
//
// Optional feature macro: PIPE_SPEEDUP_EN (speed rises every 8th respawn).
// Ports:
//   clk                  in   system clock
//   reset                in   synchronous active-low reset
//   tick                 in   frame strobe, one clk wide
//   start                in   begin or restart play
//   game_over            in   collision flag from the detector
//   pipeN_x0 / pipeN_x1  out  left/right pipe edges, saturated to 0..1023
//   pipeN_y0 / pipeN_y1  out  gap bottom / gap top
//   running              out  high while in RUN
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int SCREEN_W  = 640,
  parameter int PIPE_W    = 40,
  parameter int SPACING   = 240,
  parameter int GAP_H     = 120,
  parameter int GAP_MIN   = 40,
  parameter int SPEED     = 4,
  parameter int SPEED_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           start,
  input  logic           game_over,
  output logic [X_W-1:0] pipe1_x0,
  output logic [X_W-1:0] pipe1_x1,
  output logic [X_W-1:0] pipe2_x0,
  output logic [X_W-1:0] pipe2_x1,
  output logic [X_W-1:0] pipe3_x0,
  output logic [X_W-1:0] pipe3_x1,
  output logic [Y_W-1:0] pipe1_y0,
  output logic [Y_W-1:0] pipe1_y1,
  output logic [Y_W-1:0] pipe2_y0,
  output logic [Y_W-1:0] pipe2_y1,
  output logic [Y_W-1:0] pipe3_y0,
  output logic [Y_W-1:0] pipe3_y1,
  output logic           running
);

  localparam logic signed [PX_W-1:0] PW_S    = PX_W'(PIPE_W);
  localparam logic signed [PX_W-1:0] SPC_S   = PX_W'(SPACING);
  localparam logic [Y_W-1:0]         Y1_INIT = Y_W'(GAP_MIN + 64);
  localparam logic [Y_W-1:0]         GAP_Y   = Y_W'(GAP_H);
  localparam logic [Y_W-1:0]         GMIN_Y  = Y_W'(GAP_MIN);

  scroll_state_t state, state_nx;
  logic          reload;
  logic          move;

  pipe_t         pipes    [3];
  pipe_t         pipes_nx [3];
  logic signed [PX_W-1:0] n_px [3];
  logic          respawn  [3];
  logic          any_respawn;

  logic [7:0]    lfsr_q;
  logic [7:0]    speed;
  logic [Y_W-1:0] rand_y1;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .q     (lfsr_q)
  );

  logic unused_lfsr_bit0;
  assign unused_lfsr_bit0 = lfsr_q[0];
  assign rand_y1 = GMIN_Y + {2'b00, lfsr_q[7:1]};

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    reload   = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (game_over) state_nx = HALT;
      HALT: if (start && !game_over) begin
        state_nx = RUN;
        reload   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // game_over beats a coincident tick: the frame it arrives on never moves.
  assign move    = (state == RUN) && tick && !game_over;
  assign running = (state == RUN);

  // At most one pipe respawns per tick, so the predecessor's n_px is
  // already its final post-move position for this tick.
  always_comb begin
    any_respawn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_px[i]    = pipes[i].px - $signed({4'b0000, speed});
      respawn[i] = (n_px[i] + PW_S) <= 12'sd0;
    end
    for (int i = 0; i < 3; i++) begin
      pipes_nx[i] = pipes[i];
      if (respawn[i]) begin
        any_respawn    = 1'b1;
        pipes_nx[i].px = n_px[(i + 2) % 3] + SPC_S;
        pipes_nx[i].y1 = rand_y1;
        pipes_nx[i].y0 = rand_y1 + GAP_Y;
      end else begin
        pipes_nx[i].px = n_px[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || reload) begin
      for (int i = 0; i < 3; i++) begin
        pipes[i].px <= PX_W'(SCREEN_W + i * SPACING);
        pipes[i].y1 <= Y1_INIT;
        pipes[i].y0 <= Y1_INIT + GAP_Y;
      end
    end else if (move) begin
      for (int i = 0; i < 3; i++)
        pipes[i] <= pipes_nx[i];
    end
  end

`ifdef PIPE_SPEEDUP_EN
  logic [7:0] respawn_cnt;

  always_ff @(posedge clk) begin
    if (!reset || reload) begin
      respawn_cnt <= 8'd0;
      speed       <= 8'(SPEED);
    end else if (move && any_respawn) begin
      respawn_cnt <= respawn_cnt + 8'd1;
      // Count is about to become a multiple of 8.
      if (respawn_cnt[2:0] == 3'd7 && speed < 8'(SPEED_MAX))
        speed <= speed + 8'd1;
    end
  end
`else
  logic [8:0] unused_speed_cfg;
  assign unused_speed_cfg = {any_respawn, 8'(SPEED_MAX)};
  assign speed = 8'(SPEED);
`endif

  assign pipe1_x0 = sat_x({pipes[0].px[PX_W-1], pipes[0].px});
  assign pipe1_x1 = sat_x({pipes[0].px[PX_W-1], pipes[0].px} + {PW_S[PX_W-1], PW_S});
  assign pipe2_x0 = sat_x({pipes[1].px[PX_W-1], pipes[1].px});
  assign pipe2_x1 = sat_x({pipes[1].px[PX_W-1], pipes[1].px} + {PW_S[PX_W-1], PW_S});
  assign pipe3_x0 = sat_x({pipes[2].px[PX_W-1], pipes[2].px});
  assign pipe3_x1 = sat_x({pipes[2].px[PX_W-1], pipes[2].px} + {PW_S[PX_W-1], PW_S});

  assign pipe1_y0 = pipes[0].y0;
  assign pipe1_y1 = pipes[0].y1;
  assign pipe2_y0 = pipes[1].y0;
  assign pipe2_y1 = pipes[1].y1;
  assign pipe3_y0 = pipes[2].y0;
  assign pipe3_y1 = pipes[2].y1;

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Generates and scrolls the three pipe obstacles for the Flappy Bird datapath. It drives the pipe1..pipe3 x/y bounding coordinates consumed by the collision detector and renderer, and freezes on that detector's game_over. Pipes slide left on each frame tick. A pipe that leaves the left edge respawns behind the trailing pipe with a new pseudo-random gap.

## Interface
Parameters:
- SCREEN_W, 640, visible width in pixels; x0 of pipe1 after reset.
- PIPE_W, 40, pipe width; x1 = x0 + PIPE_W.
- SPACING, 240, left-edge distance between consecutive pipes. Constraints: 3*SPACING >= SCREEN_W + PIPE_W and SPACING > PIPE_W + SPEED_MAX.
- GAP_H, 120, vertical gap height; y0 = y1 + GAP_H.
- GAP_MIN, 40, minimum gap top (y1).
- SPEED, 4, pixels moved per tick.
- SPEED_MAX, 8, speed ceiling; used only when PIPE_SPEEDUP_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  frame strobe, one clk wide.
- start  in  1  begin or restart play (level or pulse).
- game_over  in  1  collision flag (level).
- pipe1_x0, pipe1_x1, pipe2_x0, pipe2_x1, pipe3_x0, pipe3_x1  out  10  pipe left/right edges, saturated to 0..1023.
- pipe1_y0, pipe1_y1, pipe2_y0, pipe2_y1, pipe3_y0, pipe3_y1  out  9  gap bottom (y0) and gap top (y1); bird is clear when y1 < bird_y1 and bird_y0 < y0.
- running  out  1  high in RUN.

## Operation
- Internal left edge px[i] is 12-bit signed. Output x0 = clamp(px, 0, 1023). Output x1 = clamp(px + PIPE_W, 0, 1023).
- State machine:
  - IDLE: reset state. On start, go to RUN.
  - RUN: on game_over, go to HALT.
  - HALT: when start && !game_over, reload initial positions and go to RUN. start is otherwise ignored in HALT.
- Initial values (reset, or reload from HALT):
  - px = SCREEN_W, SCREEN_W+SPACING, SCREEN_W+2*SPACING for pipe1..pipe3.
  - All y1 = GAP_MIN+64 and y0 = y1+GAP_H.
  - Speed register = SPEED; respawn counter = 0.
- In RUN, on tick, each pipe computes n = px - speed.
  - If n + PIPE_W <= 0, the pipe respawns: px = (predecessor's updated px) + SPACING. Predecessors: pipe1←pipe3, pipe2←pipe1, pipe3←pipe2.
  - On respawn, y1 = GAP_MIN + lfsr[7:1] (range 40..167) and y0 = y1 + GAP_H.
  - Otherwise px = n.
- Respawn ordering:
  - The parameter constraints guarantee at most one respawn per tick.
  - The respawning pipe's predecessor uses its post-move value from the same tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Reset seed 8'hA5 (never reloaded on restart). Steps every clk in RUN, so the gap sequence depends on the timing of start.
- IDLE and HALT: all coordinates hold and the LFSR holds.
- tick in IDLE or HALT: no effect.

## Timing
- All outputs are registered. A tick sampled at edge n produces new coordinates after edge n.
- Output values during reset: pipe1 x0/x1 = 640/680; pipe2 x0/x1 = 880/920; pipe3 x0/x1 = 1023/1023 (saturated); all y1 = 104, y0 = 224; running = 0.
- tick and game_over in the same cycle while in RUN: game_over wins. No movement; HALT is entered next cycle.
- start and game_over in the same cycle in HALT: stay in HALT.
- Reset asserted mid-move: initial values take effect on that edge. The tick is lost.
- running rises the cycle after start is sampled in IDLE, and falls the cycle after game_over is sampled.

## Configuration
- PIPE_SPEEDUP_EN defined:
  - An 8-bit respawn counter increments on each respawn.
  - Every 8th respawn, speed increments by 1, saturating at SPEED_MAX.
  - The new speed applies from the next tick.
- PIPE_SPEEDUP_EN undefined: speed is constant SPEED, and the counter is not instantiated.

## Structure
- flappy_pkg:
  - Constants: screen width, x coordinate width 10, y coordinate width 9.
  - typedef pipe_t {px, y0, y1}.
  - enum scroll_state_t {IDLE, RUN, HALT}.
  - Shared with the collision detector and renderer.
- Sub-module lfsr8 (clk, reset, en, q[7:0]).
- Three pipes held as an array of pipe_t with shared per-pipe update logic.

## Test plan
- Reset low for 2 cycles, then high: pipe1 x0/x1 = 640/680, pipe3 x0 = 1023, y1 = 104, y0 = 224, running = 0. A tick in IDLE produces no change.
- start, then 1 tick: pipe1 x0 = 636, x1 = 676, pipe2 x0 = 876; running = 1 one cycle after start.
- Run 170 ticks (pipe1 px = -40 ≤ -PIPE_W): pipe1 respawns at pipe3 px + 240 = 680, with a new y1 in 40..167 and y0 = y1+120. Before that, x0 saturates at 0 while x1 keeps decreasing.
- tick and game_over together in RUN: coordinates unchanged; running = 0 next cycle; further ticks have no effect.
- In HALT:
  - start with game_over high: stays in HALT.
  - game_over low, then start: coordinates return to reset values and running = 1.
- With PIPE_SPEEDUP_EN defined, after 8 respawns: each tick decrements px by 5. After 32 respawns, speed caps at 8.
